uart_tx_sched: RTL and testbench

- Shares one uart_tx transmitter among NREQ byte sources, e.g. keyboard, answerback and status-report generators in the terminal.
- Grants round-robin, drives uart_tx's data/data_set/data_clr, and waits on its done flag before issuing the next byte.
- Guarantees uart_tx is never reloaded mid-frame, including after a reset.

---
 rtl/uart_tx_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart_tx among NREQ byte sources.
// A post-reset SYNC interval outlasts any in-flight frame, so the transmitter
// is never reloaded mid-frame, even after a reset.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   req_valid[NREQ]     requester i has a byte pending (held until acked)
//   req_data[8*NREQ]    byte of requester i in bits [8*i+7:8*i]
//   req_ack[NREQ]       one-cycle pulse: byte of requester i accepted
//   tx_data[8]          to uart_tx data[8:1]
//   tx_data_set/clr     load strobe and done-clear strobe to uart_tx
//   tx_done             done flag from uart_tx
//   busy                high whenever the scheduler is not IDLE
//
// Optional feature macro UART_XONXOFF_EN adds XON/XOFF flow control:
//   rxbuf_high, rxbuf_low  local receive buffer near-full / drained
//   rx_data, rx_strobe     received byte and its one-cycle valid
//   host_paused            host has sent XOFF; requesters are held off
module uart_tx_sched #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned INCLK = 50000000,
    parameter int unsigned BAUD  = 9600
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ack,
    output logic [7:0]        tx_data,
    output logic              tx_data_set,
    output logic              tx_data_clr,
    input  logic              tx_done,
    output logic              busy
`ifdef UART_XONXOFF_EN
    ,
    input  logic              rxbuf_high,
    input  logic              rxbuf_low,
    input  logic [7:0]        rx_data,
    input  logic              rx_strobe,
    output logic              host_paused
`endif
);

    // 12 bit times covers a full frame with 2 stop bits plus margin.
    localparam int unsigned SYNC_CYC  = 32'((64'(INCLK) * 64'd12) / 64'(BAUD));
    localparam int unsigned SYNC_LAST = (SYNC_CYC > 0) ? SYNC_CYC - 1 : 0;
    localparam int unsigned PW        = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_SYNC,
        S_IDLE,
        S_LOAD,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       sync_cnt_q, sync_cnt_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [7:0]        tx_data_d;
    logic              set_d, clr_d, busy_d;
    logic [NREQ-1:0]   ack_d;
    logic [NREQ-1:0]   elig;
    logic              any_req;
    logic [PW-1:0]     grant;
    logic [7:0]        grant_byte;

`ifdef UART_XONXOFF_EN
    localparam logic [7:0] XON  = 8'h11;
    localparam logic [7:0] XOFF = 8'h13;

    logic       high_q, low_q;
    logic       pend_q, pend_d;
    logic [7:0] code_q, code_d;
    logic       sent_xoff_q, sent_xoff_d;
    logic       paused_d;
    logic       rise_high, rise_low;
`endif

    // Requester eligibility: a paused host holds off every requester.
    always_comb begin
`ifdef UART_XONXOFF_EN
        elig = req_valid & {NREQ{~host_paused}};
`else
        elig = req_valid;
`endif
    end

    // Round-robin pick: lowest eligible index at or above rr_q, wrapping.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        any_req    = 1'b0;
        grant      = '0;
        grant_byte = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_req && elig[idx]) begin
                any_req    = 1'b1;
                grant      = PW'(idx);
                grant_byte = req_data[8*idx +: 8];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        rr_d       = rr_q;
        tx_data_d  = tx_data;
        set_d      = 1'b0;
        clr_d      = 1'b0;
        ack_d      = '0;
`ifdef UART_XONXOFF_EN
        pend_d      = pend_q;
        code_d      = code_q;
        sent_xoff_d = sent_xoff_q;
        paused_d    = host_paused;
        rise_high   = rxbuf_high & ~high_q;
        rise_low    = rxbuf_low & ~low_q;
`endif

        case (state_q)
            S_SYNC: begin
                if (sync_cnt_q >= 32'(SYNC_LAST)) begin
                    sync_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    sync_cnt_d = sync_cnt_q + 32'd1;
                end
            end
            S_IDLE: begin
`ifdef UART_XONXOFF_EN
                // Flow-control codes jump the queue; no ack, rr untouched.
                if (pend_q) begin
                    tx_data_d = code_q;
                    set_d     = 1'b1;
                    clr_d     = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = S_LOAD;
                end else
`endif
                if (any_req) begin
                    tx_data_d   = grant_byte;
                    set_d       = 1'b1;
                    clr_d       = 1'b1;
                    ack_d[grant] = 1'b1;
                    rr_d        = (grant == PW'(NREQ - 1)) ? '0 : grant + PW'(1);
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done was cleared by the LOAD strobe, so a high here is fresh.
                if (tx_done) state_d = S_IDLE;
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

`ifdef UART_XONXOFF_EN
        // A newer code replaces an unsent one.
        if (rise_high && !sent_xoff_q) begin
            pend_d      = 1'b1;
            code_d      = XOFF;
            sent_xoff_d = 1'b1;
        end else if (rise_low && sent_xoff_q) begin
            pend_d      = 1'b1;
            code_d      = XON;
            sent_xoff_d = 1'b0;
        end

        if (rx_strobe) begin
            if (rx_data == XOFF) begin
                paused_d = 1'b1;
            end else if (rx_data == XON) begin
                paused_d = 1'b0;
            end
        end
`endif

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_SYNC;
            sync_cnt_q  <= '0;
            rr_q        <= '0;
            tx_data     <= '0;
            tx_data_set <= 1'b0;
            tx_data_clr <= 1'b0;
            req_ack     <= '0;
            busy        <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            rr_q        <= rr_d;
            tx_data     <= tx_data_d;
            tx_data_set <= set_d;
            tx_data_clr <= clr_d;
            req_ack     <= ack_d;
            busy        <= busy_d;
        end
    end

`ifdef UART_XONXOFF_EN
    // Flow-control state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high_q      <= 1'b0;
            low_q       <= 1'b0;
            pend_q      <= 1'b0;
            code_q      <= '0;
            sent_xoff_q <= 1'b0;
            host_paused <= 1'b0;
        end else begin
            high_q      <= rxbuf_high;
            low_q       <= rxbuf_low;
            pend_q      <= pend_d;
            code_q      <= code_d;
            sent_xoff_q <= sent_xoff_d;
            host_paused <= paused_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: scoreboard of expected bytes filled by a
// round-robin reference model, monitor compares on every tx_data_set.
module tb_uart_tx_sched;

    localparam int unsigned NREQ     = 3;
    localparam int unsigned INCLK    = 1000000;
    localparam int unsigned BAUD     = 100000;
    localparam int unsigned SYNC_CYC = 12 * INCLK / BAUD;
    localparam int          FRAME    = 25;

    typedef struct {
        int         idx;     // -1: flow-control code, no ack expected
        logic [7:0] b;
        bit         chain;   // data_set must be exactly 2 clk after done rise
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ack;
    logic [7:0]        tx_data;
    logic              tx_data_set, tx_data_clr;
    logic              tx_done = 1'b1;
    logic              busy;
`ifdef UART_XONXOFF_EN
    logic              rxbuf_high = 1'b0;
    logic              rxbuf_low = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_strobe = 1'b0;
    logic              host_paused;
`endif

    uart_tx_sched #(.NREQ(NREQ), .INCLK(INCLK), .BAUD(BAUD)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_data     (tx_data),
        .tx_data_set (tx_data_set),
        .tx_data_clr (tx_data_clr),
        .tx_done     (tx_done),
        .busy        (busy)
`ifdef UART_XONXOFF_EN
        ,
        .rxbuf_high  (rxbuf_high),
        .rxbuf_low   (rxbuf_low),
        .rx_data     (rx_data),
        .rx_strobe   (rx_strobe),
        .host_paused (host_paused)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model: load on data_set, done low for FRAME cycles, clear on data_clr.
    int frame_left = 0;
    always @(posedge clk) begin
        if (tx_data_set) begin
            frame_left <= FRAME;
            tx_done    <= 1'b0;
        end else if (tx_data_clr) begin
            tx_done <= 1'b0;
        end else if (frame_left > 0) begin
            frame_left <= frame_left - 1;
            if (frame_left == 1) tx_done <= 1'b1;
        end
    end

    logic [7:0] rq [NREQ][$];
    exp_t       sb [$];
    int         m_rr = 0;
    int         checks = 0;
    int         errors = 0;
    int         last_set_cyc = 0;
    int         rise_cyc = 0;
    logic       prev_done = 1'b1;
    bit         post_load = 1'b0;

    task automatic check(input bit ok, input string name, input int got, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, got, req, cyc);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = (rq[i].size() > 0);
            req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++)
            if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        refresh();
    endtask

    // Reference: all queued bytes present at once, served round-robin among non-empty sources.
    task automatic model_batch();
        int pos [NREQ];
        int total;
        exp_t e;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos[i] = 0;
            total += rq[i].size();
        end
        for (int k = 0; k < total; k++) begin
            int j;
            j = -1;
            for (int s = 0; s < NREQ; s++) begin
                int c;
                c = (m_rr + s) % NREQ;
                if (j < 0 && pos[c] < rq[c].size()) j = c;
            end
            e.idx = j;
            e.b = rq[j][pos[j]];
            e.chain = (k > 0);
            sb.push_back(e);
            pos[j]++;
            m_rr = (j + 1) % NREQ;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 4000) begin
            step();
            n++;
        end
        check(n < 4000, {"drain_", tag}, sb.size(), 0);
        if (n >= 4000) sb.delete();
    endtask

    task automatic push_exp(input int idx, input logic [7:0] b, input bit chain);
        exp_t e;
        e.idx = idx;
        e.b = b;
        e.chain = chain;
        sb.push_back(e);
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                logic [NREQ-1:0] ea;
                forever begin
                    @(negedge clk);
                    if (tx_done && !prev_done) rise_cyc = cyc;
                    prev_done = tx_done;
                    if (post_load)
                        check(!tx_data_set && !tx_data_clr && req_ack == '0, "strobe_width",
                              {tx_data_set, tx_data_clr, 8'(req_ack)}, 0);
                    post_load = tx_data_set;
                    if (tx_data_set) begin
                        last_set_cyc = cyc;
                        check(frame_left == 0, "reload_mid_frame", frame_left, 0);
                        if (sb.size() == 0) begin
                            check(1'b0, "unexpected_data_set", tx_data, 0);
                        end else begin
                            e = sb.pop_front();
                            ea = '0;
                            if (e.idx >= 0) ea[e.idx] = 1'b1;
                            check(tx_data == e.b, "tx_data", tx_data, e.b);
                            check(req_ack == ea, "req_ack", req_ack, ea);
                            check(tx_data_clr == 1'b1, "data_clr", tx_data_clr, 1);
                            if (e.chain)
                                check(cyc - rise_cyc == 2, "done_to_set", cyc - rise_cyc, 2);
                        end
                    end
                end
            end
            begin : stimulus
                int rel_cyc;
                int gap;
                int n;
                // Reset release with requester 0 holding 8'h41 from cycle 0.
                rq[0].push_back(8'h41);
                model_batch();
                refresh();
                repeat (3) step();
                check(busy === 1'b1, "reset_busy", busy, 1);
                check(tx_data === 8'h00 && tx_data_set === 1'b0 && tx_data_clr === 1'b0,
                      "reset_tx", {tx_data_set, tx_data_clr, tx_data}, 0);
                check(req_ack === '0, "reset_ack", req_ack, 0);
                reset_n = 1'b1;
                rel_cyc = cyc;
                wait_done("first");
                gap = last_set_cyc - rel_cyc;
                check(gap >= int'(SYNC_CYC) && gap <= int'(SYNC_CYC) + 2, "sync_quiet", gap, SYNC_CYC + 1);
                check(busy === 1'b0, "idle_busy", busy, 0);

                // Two sources streaming continuously alternate.
                repeat (4) begin
                    rq[0].push_back(8'h31);
                    rq[1].push_back(8'h32);
                end
                model_batch();
                wait_done("alternate");

                // Random batches, random source subsets and lengths.
                for (int b = 0; b < 8; b++) begin
                    for (int i = 0; i < NREQ; i++) begin
                        int cnt;
                        cnt = $urandom_range(0, 4);
                        repeat (cnt) rq[i].push_back(8'($urandom));
                    end
                    model_batch();
                    wait_done("random");
                end

`ifdef UART_XONXOFF_EN
                // XOFF queued while a byte is in flight beats the next requester.
                rq[0].push_back(8'hA5);
                model_batch();
                n = 0;
                while (sb.size() != 0 && n < 2000) begin step(); n++; end
                rq[1].push_back(8'h5C);
                rxbuf_high = 1'b1;
                push_exp(-1, 8'h13, 1'b1);
                push_exp(1, 8'h5C, 1'b1);
                m_rr = 2;
                step();
                rxbuf_high = 1'b0;
                wait_done("xoff");
                rxbuf_low = 1'b1;
                push_exp(-1, 8'h11, 1'b0);
                step();
                rxbuf_low = 1'b0;
                wait_done("xon");

                // Host pause holds requesters until XON arrives.
                rx_data = 8'h13;
                rx_strobe = 1'b1;
                step();
                rx_strobe = 1'b0;
                step();
                rq[2].push_back(8'h77);
                repeat (50) step();
                check(host_paused === 1'b1, "host_paused", host_paused, 1);
                check(busy === 1'b0, "paused_idle", busy, 0);
                rx_data = 8'h11;
                rx_strobe = 1'b1;
                rel_cyc = cyc;
                push_exp(2, 8'h77, 1'b0);
                m_rr = 0;
                step();
                rx_strobe = 1'b0;
                wait_done("resume");
                check(last_set_cyc - rel_cyc == 2, "resume_latency", last_set_cyc - rel_cyc, 2);
`endif

                // Reset in the middle of WAIT abandons the byte and repeats SYNC.
                repeat (3) rq[0].push_back(8'($urandom));
                model_batch();
                n = 0;
                while (sb.size() > 2 && n < 2000) begin step(); n++; end
                repeat (5) step();
                @(posedge clk);
                #2 reset_n = 1'b0;
                #1;
                check(busy === 1'b1, "async_busy", busy, 1);
                check(tx_data === 8'h00, "async_tx_data", tx_data, 0);
                check(tx_data_set === 1'b0 && tx_data_clr === 1'b0, "async_strobes",
                      {tx_data_set, tx_data_clr}, 0);
                check(req_ack === '0, "async_ack", req_ack, 0);
                for (int i = 0; i < NREQ; i++) rq[i].delete();
                sb.delete();
                m_rr = 0;
                repeat (3) step();
                rq[0].push_back(8'h5A);
                model_batch();
                refresh();
                reset_n = 1'b1;
                rel_cyc = cyc;
                wait_done("after_reset");
                gap = last_set_cyc - rel_cyc;
                check(gap >= int'(SYNC_CYC) && gap <= int'(SYNC_CYC) + 2, "resync_quiet", gap, SYNC_CYC + 1);

                repeat (5) step();
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        join
    end

endmodule
